// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 800x600@72 vertical timing constants, framebuffer geometry and arbiter states
package vga_timing_pkg;
  localparam int H_VISIBLE = 800;
  localparam int V_VISIBLE = 600;
  localparam int V_FRONT = 37;
  localparam int V_PULSE = 6;
  localparam int V_BACK = 23;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_PULSE + V_BACK;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END = VS_START + V_PULSE - 1;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int LW = 10;
  localparam int FB_DEPTH = H_VISIBLE * V_VISIBLE;
  typedef enum logic [1:0] {BLANK, SCAN, WRITE} arb_state_t;
endpackage

// File: rtl/vga_line_counter.sv
// vga_line_counter: counts line strobes into vertical timing flags and the frame wrap
module vga_line_counter
  import vga_timing_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic line_end,
  output logic wrap,
  output logic v_sync,
  output logic v_active,
  output logic frame_start
);
  logic [LW-1:0] line_cnt, nxt;
  assign wrap = line_end && line_cnt == LW'(V_TOTAL - 1);
  assign nxt = wrap ? '0 : line_cnt + LW'(1);
  // flags are computed from the next count so they always describe the current line
  always_ff @(posedge clk)
    if (!rst) begin
      line_cnt <= '0;
      v_sync <= 1'b0;
      v_active <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (line_end) begin
        line_cnt <= nxt;
        v_active <= nxt < LW'(V_VISIBLE);
        v_sync <= nxt >= LW'(VS_START) && nxt <= LW'(VS_END);
      end
    end
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one framebuffer port between the video scan and a blanking-time writer
module vga_fb_arbiter
  import vga_timing_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          line_end,
  input  logic          display_en,
  output logic          v_sync,
  output logic          v_active,
  output logic          frame_start,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack
);
  arb_state_t state;
  logic wrap, scan, issue;
  logic [AW-1:0] base, col, base_e, col_e;
  vga_line_counter u_lines (
    .clk(clk),
    .rst(rst),
    .line_end(line_end),
    .wrap(wrap),
    .v_sync(v_sync),
    .v_active(v_active),
    .frame_start(frame_start)
  );
  assign scan = display_en && v_active;
  assign issue = !scan && state != SCAN && wr_req && !wr_ack;
  assign base_e = wrap ? '0 : (line_end && v_active) ? base + AW'(H_VISIBLE) : base;
  assign col_e = line_end ? '0 : col;
  assign pix_data = mem_rdata;
  // port arbitration: scan preempts, a held request is issued once on a free cycle after a free cycle
  always_ff @(posedge clk)
    if (!rst) begin
      state <= BLANK;
      base <= '0;
      col <= '0;
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_wdata <= '0;
      pix_valid <= 1'b0;
      wr_ack <= 1'b0;
    end else begin
      base <= base_e;
      col <= col_e + AW'(scan);
      pix_valid <= state == SCAN;
      mem_we <= issue && wr_addr < AW'(FB_DEPTH);
      wr_ack <= issue;
      state <= scan ? SCAN : issue ? WRITE : BLANK;
      if (scan) mem_addr <= base_e + col_e;
      else if (issue) begin
        mem_addr <= wr_addr;
        mem_wdata <= wr_data;
      end
    end
endmodule
